// File: rtl/deser_link_arbiter.sv
// deser_link_arbiter
// Round-robin scheduler sharing one serial link into a byte deserializer
// between NUM_REQ byte requesters. Each transfer shifts the granted byte out
// MSB-first as 8 strobed bits, waits for the deserializer's ready, acks it,
// reports the received byte and signals done (or err on timeout).
// Optional feature macro: LOOPBACK_CHECK_EN adds a 'mismatch' output and
// compares the returned byte against the byte that was sent.

module deser_link_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                       clk_100KHz,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic                       busy,
    output logic                       ser_data_out,
    output logic                       ser_write_out,
    input  logic                       deser_ready_in,
    input  logic [7:0]                 deser_data_in,
    output logic                       deser_ack_out,
    output logic [7:0]                 rx_byte,
    output logic                       rx_valid,
    output logic [$clog2(NUM_REQ)-1:0] rx_src
`ifdef LOOPBACK_CHECK_EN
    ,
    output logic                       mismatch
`endif
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TCNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_RDY = 2'd2,
        ACK      = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   last_grant;
    logic [7:0]         shreg;
    logic [2:0]         bit_cnt;
    logic [TCNT_W-1:0]  tcnt;
    logic [IDX_W-1:0]   rr_winner;
    logic               rr_hit;
    logic [7:0]         req_bytes [NUM_REQ];

`ifdef LOOPBACK_CHECK_EN
    logic [7:0]         sent_byte;
    logic               mm_flag;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_bytes
            assign req_bytes[g] = req_data[8*g +: 8];
        end
    endgenerate

    // Index 'offs' positions after 'base', wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int offs);
        int s;
        s = base + offs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin search: first active request after the last grant wins.
    always_comb begin
        rr_hit    = 1'b0;
        rr_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!rr_hit && req[wrap_idx(int'(last_grant), k)]) begin
                rr_hit    = 1'b1;
                rr_winner = wrap_idx(int'(last_grant), k);
            end
        end
    end

    // Transfer FSM; every output is registered here and pulses default low.
    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= IDX_LAST;
            shreg         <= '0;
            bit_cnt       <= '0;
            tcnt          <= '0;
            done          <= '0;
            err           <= '0;
            busy          <= 1'b0;
            ser_data_out  <= 1'b0;
            ser_write_out <= 1'b0;
            deser_ack_out <= 1'b0;
            rx_byte       <= '0;
            rx_valid      <= 1'b0;
            rx_src        <= '0;
`ifdef LOOPBACK_CHECK_EN
            sent_byte     <= '0;
            mm_flag       <= 1'b0;
            mismatch      <= 1'b0;
`endif
        end else begin
            done          <= '0;
            err           <= '0;
            rx_valid      <= 1'b0;
            ser_write_out <= 1'b0;
            ser_data_out  <= 1'b0;
`ifdef LOOPBACK_CHECK_EN
            mismatch      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rr_hit) begin
                        shreg      <= req_bytes[rr_winner];
                        grant      <= rr_winner;
                        last_grant <= rr_winner;
                        bit_cnt    <= '0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
`ifdef LOOPBACK_CHECK_EN
                        sent_byte  <= req_bytes[rr_winner];
                        mm_flag    <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
                    ser_write_out <= 1'b1;
                    ser_data_out  <= shreg[7];
                    shreg         <= {shreg[6:0], 1'b0};
                    bit_cnt       <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        tcnt  <= '0;
                        state <= WAIT_RDY;
                    end
                end

                WAIT_RDY: begin
                    if (deser_ready_in) begin
                        rx_byte       <= deser_data_in;
                        rx_src        <= grant;
                        rx_valid      <= 1'b1;
                        deser_ack_out <= 1'b1;
                        tcnt          <= '0;
                        state         <= ACK;
`ifdef LOOPBACK_CHECK_EN
                        if (deser_data_in != sent_byte) begin
                            mismatch <= 1'b1;
                            mm_flag  <= 1'b1;
                        end
`endif
                    end else if (tcnt == TCNT_LAST) begin
                        err[grant] <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                ACK: begin
                    if (!deser_ready_in) begin
                        deser_ack_out <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
`ifdef LOOPBACK_CHECK_EN
                        if (mm_flag) begin
                            err[grant] <= 1'b1;
                        end else begin
                            done[grant] <= 1'b1;
                        end
`else
                        done[grant] <= 1'b1;
`endif
                    end else if (tcnt == TCNT_LAST) begin
                        deser_ack_out <= 1'b0;
                        err[grant]    <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deser_link_arbiter.sv
// Testbench for deser_link_arbiter: directed vector table, hand-written reset
// sequence and randomized transfers against a transaction-level model.
// Build with LOOPBACK_CHECK_EN defined to exercise the mismatch feature.
`timescale 1ns/1ps

module tb_deser_link_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ACK_TIMEOUT = 16;
    localparam int BUDGET      = 200;
    localparam int M_NORMAL    = 0;
    localparam int M_NO_READY  = 1;
    localparam int M_STUCK     = 2;
`ifdef LOOPBACK_CHECK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic                 clk_100KHz;
    logic                 reset;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic                 busy;
    logic                 ser_data_out;
    logic                 ser_write_out;
    logic                 deser_ready_in;
    logic [7:0]           deser_data_in;
    logic                 deser_ack_out;
    logic [7:0]           rx_byte;
    logic                 rx_valid;
    logic [1:0]           rx_src;
`ifdef LOOPBACK_CHECK_EN
    logic                 mismatch;
`endif

    int checks = 0;
    int errors = 0;
    int model_lg;

    // Deserializer model state
    int         m_phase;
    int         m_bits;
    int         m_cnt;
    int         m_mode;
    int         m_ddly;
    int         m_rdly;
    logic [7:0] m_byte;
    logic [7:0] m_corrupt;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        int          rdly;
        int          ddly;
        int          mode;
        logic [7:0]  corrupt;
        int          exp_w;
        bit          exp_err;
    } vec_t;

    vec_t vecs [12];

    deser_link_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_100KHz     (clk_100KHz),
        .reset          (reset),
        .req            (req),
        .req_data       (req_data),
        .done           (done),
        .err            (err),
        .busy           (busy),
        .ser_data_out   (ser_data_out),
        .ser_write_out  (ser_write_out),
        .deser_ready_in (deser_ready_in),
        .deser_data_in  (deser_data_in),
        .deser_ack_out  (deser_ack_out),
        .rx_byte        (rx_byte),
        .rx_valid       (rx_valid),
        .rx_src         (rx_src)
`ifdef LOOPBACK_CHECK_EN
        ,
        .mismatch       (mismatch)
`endif
    );

    // Free-running clock
    initial clk_100KHz = 1'b0;
    always #5 clk_100KHz = ~clk_100KHz;

    // Hard stop in case something hangs outside the bounded loops
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic model_arm(input int mode, input int rdly, input int ddly, input logic [7:0] corrupt);
        m_phase        = 0;
        m_bits         = 0;
        m_byte         = 8'h00;
        m_cnt          = 0;
        m_mode         = mode;
        m_rdly         = rdly;
        m_ddly         = ddly;
        m_corrupt      = corrupt;
        deser_ready_in = 1'b0;
        deser_data_in  = 8'h00;
    endtask

    // Behavioural deserializer: collect 8 strobed bits, raise ready after a
    // delay, drop it a programmable time after ack (or never, per mode).
    task automatic deser_model();
        if (m_phase == 0 && ser_write_out) begin
            m_byte = {m_byte[6:0], ser_data_out};
            m_bits++;
            if (m_bits == 8) begin
                m_phase = 1;
                m_cnt   = m_rdly;
            end
        end
        if (m_phase == 1 && m_mode != M_NO_READY) begin
            if (m_cnt == 0) begin
                deser_ready_in = 1'b1;
                deser_data_in  = m_byte ^ m_corrupt;
                m_phase        = 2;
            end else begin
                m_cnt--;
            end
        end
        if (m_phase == 2 && deser_ack_out && m_mode != M_STUCK) begin
            m_cnt   = m_ddly;
            m_phase = 3;
        end
        if (m_phase == 3) begin
            if (m_cnt == 0) begin
                deser_ready_in = 1'b0;
                m_phase        = 4;
            end else begin
                m_cnt--;
            end
        end
    endtask

    // Advance one clock, then sample and let the deserializer model react.
    task automatic applyStimulus();
        @(posedge clk_100KHz);
        #1;
        deser_model();
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_busy"},  32'(busy), 32'd0);
        checkOutput({tag, "_wr"},    32'(ser_write_out), 32'd0);
        checkOutput({tag, "_sd"},    32'(ser_data_out), 32'd0);
        checkOutput({tag, "_ack"},   32'(deser_ack_out), 32'd0);
        checkOutput({tag, "_done"},  32'(done), 32'd0);
        checkOutput({tag, "_err"},   32'(err), 32'd0);
        checkOutput({tag, "_rxb"},   32'(rx_byte), 32'd0);
        checkOutput({tag, "_rxv"},   32'(rx_valid), 32'd0);
        checkOutput({tag, "_rxs"},   32'(rx_src), 32'd0);
`ifdef LOOPBACK_CHECK_EN
        checkOutput({tag, "_mm"},    32'(mismatch), 32'd0);
`endif
    endtask

    // One complete transfer from IDLE, checked at transaction level.
    task automatic run_transfer(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*8-1:0] data,
                                input int rdly, input int ddly, input int mode,
                                input logic [7:0] corrupt, input int exp_w, input bit exp_err,
                                input bit perturb, input string tag);
        int t, first, last, strobes, gap, rxv_cnt, rxs_seen, ack_cnt, busy_low, end_t, mm_cnt, mm_ok;
        int exp_end, exp_ack, exp_rxv;
        logic [7:0] shifted, rx_seen, sent;
        logic [NUM_REQ-1:0] done_seen, err_seen, one;
        bit finished;
        sent = data[8*exp_w +: 8];
        one  = '0;
        one[exp_w] = 1'b1;
        t = 0; first = -1; last = -1; strobes = 0; gap = 0; rxv_cnt = 0; rxs_seen = -1;
        ack_cnt = 0; busy_low = 0; end_t = -1; mm_cnt = 0; mm_ok = 0;
        shifted = 8'h00; rx_seen = 8'h00; done_seen = '0; err_seen = '0; finished = 1'b0;
        req      = mask;
        req_data = data;
        model_arm(mode, rdly, ddly, corrupt);
        while (!finished && t < BUDGET) begin
            applyStimulus();
            t++;
            if (perturb && t == 4) begin
                req_data   = ~req_data;
                req[exp_w] = 1'b0;
            end
            if (ser_write_out) begin
                if (first < 0) first = t;
                else if (t != last + 1) gap = 1;
                last = t;
                strobes++;
                shifted = {shifted[6:0], ser_data_out};
            end
            if (rx_valid) begin
                rxv_cnt++;
                rx_seen  = rx_byte;
                rxs_seen = int'(rx_src);
            end
`ifdef LOOPBACK_CHECK_EN
            if (mismatch) begin
                mm_cnt++;
                if (rx_valid) mm_ok++;
            end
`endif
            if (deser_ack_out) ack_cnt++;
            if (done != '0 || err != '0) begin
                finished  = 1'b1;
                end_t     = t;
                done_seen = done;
                err_seen  = err;
                checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
                checkOutput({tag, "_ack_end"},  32'(deser_ack_out), 32'd0);
            end else if (!busy) begin
                busy_low++;
            end
        end
        checkOutput({tag, "_finished"}, 32'(finished), 32'd1);
        if (mode == M_NO_READY) begin
            exp_end = 9 + ACK_TIMEOUT;  exp_ack = 0;           exp_rxv = 0;
        end else if (mode == M_STUCK) begin
            exp_end = 10 + rdly + ACK_TIMEOUT; exp_ack = ACK_TIMEOUT; exp_rxv = 1;
        end else begin
            exp_end = 11 + rdly + ddly; exp_ack = 1 + ddly;    exp_rxv = 1;
        end
        checkOutput({tag, "_first_strobe"}, first, 2);
        checkOutput({tag, "_last_strobe"},  last, 9);
        checkOutput({tag, "_strobes"},      strobes, 8);
        checkOutput({tag, "_gap"},          gap, 0);
        checkOutput({tag, "_ser_byte"},     32'(shifted), 32'(sent));
        checkOutput({tag, "_end_cycle"},    end_t, exp_end);
        checkOutput({tag, "_ack_cycles"},   ack_cnt, exp_ack);
        checkOutput({tag, "_busy_low"},     busy_low, 0);
        checkOutput({tag, "_rxv_cnt"},      rxv_cnt, exp_rxv);
        if (exp_rxv == 1) begin
            checkOutput({tag, "_rx_byte"}, 32'(rx_seen), 32'(sent ^ corrupt));
            checkOutput({tag, "_rx_src"},  rxs_seen, exp_w);
        end
        checkOutput({tag, "_done"}, 32'(done_seen), exp_err ? 32'd0 : 32'(one));
        checkOutput({tag, "_err"},  32'(err_seen),  exp_err ? 32'(one) : 32'd0);
`ifdef LOOPBACK_CHECK_EN
        checkOutput({tag, "_mm_cnt"}, mm_cnt, (corrupt != 8'h00 && exp_rxv == 1) ? 1 : 0);
        checkOutput({tag, "_mm_with_rxv"}, mm_ok, mm_cnt);
`endif
        model_lg = exp_w;
    endtask

    initial begin
        int strobes, t, w, idx, rd, dd;
        logic [3:0] m;
        logic [7:0] cor;
        bit ee;

        // Directed vectors: {mask, data, ready delay, drop delay, mode, corrupt, winner, err}
        vecs[0]  = '{4'b1111, 32'h44332211, 1, 0, M_NORMAL,   8'h00, 0, 1'b0};
        vecs[1]  = '{4'b1111, 32'h44332211, 1, 0, M_NORMAL,   8'h00, 1, 1'b0};
        vecs[2]  = '{4'b1111, 32'h44332211, 1, 0, M_NORMAL,   8'h00, 2, 1'b0};
        vecs[3]  = '{4'b1111, 32'h44332211, 1, 0, M_NORMAL,   8'h00, 3, 1'b0};
        vecs[4]  = '{4'b1111, 32'h44332211, 1, 0, M_NORMAL,   8'h00, 0, 1'b0};
        vecs[5]  = '{4'b0001, 32'h000000A5, 2, 1, M_NORMAL,   8'h00, 0, 1'b0};
        vecs[6]  = '{4'b0100, 32'h00C30000, 0, 0, M_NO_READY, 8'h00, 2, 1'b1};
        vecs[7]  = '{4'b1000, 32'h5A000000, 1, 0, M_STUCK,    8'h00, 3, 1'b1};
        vecs[8]  = '{4'b0110, 32'h007E8100, 0, 0, M_NORMAL,   8'h00, 1, 1'b0};
        vecs[9]  = '{4'b0110, 32'h007E8100, 3, 2, M_NORMAL,   8'h00, 2, 1'b0};
        vecs[10] = '{4'b1001, 32'hF000000F, 0, 0, M_NORMAL,   8'h00, 3, 1'b0};
        vecs[11] = '{4'b0001, 32'h0000003C, 1, 1, M_NORMAL,   8'h01, 0, LOOPBACK};

        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        model_arm(M_NORMAL, 0, 0, 8'h00);
        repeat (2) @(posedge clk_100KHz);
        #2;
        check_all_zero("reset");
        reset = 1'b0;
        model_lg = NUM_REQ - 1;

        for (int i = 0; i < 12; i++) begin
            run_transfer(vecs[i].mask, vecs[i].data, vecs[i].rdly, vecs[i].ddly, vecs[i].mode,
                         vecs[i].corrupt, vecs[i].exp_w, vecs[i].exp_err, 1'b0,
                         $sformatf("vec%0d", i));
        end

        // Reset in the middle of a shift, then a fresh grant for requester 1
        req      = 4'b0001;
        req_data = 32'h000000F0;
        model_arm(M_NORMAL, 0, 0, 8'h00);
        strobes = 0;
        t = 0;
        while (strobes < 4 && t < 20) begin
            applyStimulus();
            t++;
            if (ser_write_out) strobes++;
        end
        checkOutput("midrst_strobes", strobes, 4);
        reset = 1'b1;
        #1;
        check_all_zero("midrst_async");
        req      = 4'b0010;
        req_data = 32'h00009600;
        @(posedge clk_100KHz);
        #2;
        check_all_zero("midrst_held");
        reset = 1'b0;
        model_lg = NUM_REQ - 1;
        run_transfer(4'b0010, 32'h00009600, 1, 0, M_NORMAL, 8'h00, 1, 1'b0, 1'b0, "after_rst");

        // Randomized transfers against the round-robin reference model
        for (int n = 0; n < 25; n++) begin
            m  = 4'($urandom_range(1, 15));
            w  = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (model_lg + k) % NUM_REQ;
                if (w < 0 && m[idx]) w = idx;
            end
            rd  = $urandom_range(0, 4);
            dd  = $urandom_range(0, 3);
            cor = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            ee  = LOOPBACK && (cor != 8'h00);
            run_transfer(m, 32'($urandom), rd, dd, M_NORMAL, cor, w, ee,
                         1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deser_link_arbiter.md
Name: deser_link_arbiter

Overview:
- Round-robin scheduler that shares one serial link into the byte deserializer between NUM_REQ parallel byte requesters.
- Per transfer: grants one requester, shifts its byte MSB-first as 8 serial bits, waits for the deserializer's ready, acks it, reports the received byte, and signals done to the requester.
- Sits between on-chip byte producers and the deserializer, in the clk_100KHz domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ACK_TIMEOUT, 64, maximum cycles to wait in WAIT_RDY or ACK before aborting the transfer.

Ports:
- clk_100KHz  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; held until the matching done or err.
- req_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- done  output  NUM_REQ  one-cycle pulse on successful completion for the granted requester.
- err  output  NUM_REQ  one-cycle pulse on timeout for the granted requester.
- busy  output  1  high in every state except IDLE.
- ser_data_out  output  1  serial bit to the deserializer data input.
- ser_write_out  output  1  bit strobe to the deserializer write input.
- deser_ready_in  input  1  deserializer byte-ready flag.
- deser_data_in  input  8  deserializer parallel byte.
- deser_ack_out  output  1  acknowledge to the deserializer.
- rx_byte  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse when rx_byte updates.
- rx_src  output  $clog2(NUM_REQ)  index of the requester that owns rx_byte.

Behaviour:
- All outputs are registered. On reset, every output is 0, the state is IDLE, and last_grant = NUM_REQ-1, so requester 0 has highest priority first.
- Reset asserted in any state aborts the transfer immediately. No done or err is issued for the aborted transfer.
- States: IDLE, SHIFT, WAIT_RDY, ACK.
- IDLE:
  - Search req starting at last_grant+1, wrapping modulo NUM_REQ.
  - On a hit: latch req_data of the winner into shreg, set grant and last_grant to the winner, clear the bit counter, go to SHIFT.
  - No request means stay in IDLE.
- SHIFT:
  - Each cycle drive ser_write_out=1 and ser_data_out=shreg[7], then shift shreg left.
  - Exactly 8 consecutive strobe cycles, with no gaps.
  - After the 8th bit, drive ser_write_out=0 the next cycle and go to WAIT_RDY. Clear the timeout counter.
- WAIT_RDY:
  - If deser_ready_in=1: set rx_byte=deser_data_in, rx_src=grant, pulse rx_valid; set deser_ack_out=1; go to ACK.
  - If the timeout counter reaches ACK_TIMEOUT: pulse err[grant], go to IDLE.
- ACK:
  - Hold deser_ack_out=1 until deser_ready_in=0.
  - Then deser_ack_out=0, pulse done[grant], go to IDLE.
  - If ACK_TIMEOUT cycles elapse first: drop ack, pulse err[grant], go to IDLE.
- The timeout counter restarts on entry to each of WAIT_RDY and ACK.
- Latency: from IDLE to the first strobe is 1 cycle; the minimum transfer is 1 + 8 + 1 + 1 = 11 cycles. The first IDLE evaluation after done can grant again.
- A requester that drops req mid-transfer does not abort it; done or err is still pulsed.
- req_data is sampled only at grant. Later changes are ignored for that transfer.
- If requester i holds req continuously, it waits behind every other active requester (fairness).
- done and err are never asserted in the same cycle and are one-hot to grant.

Optional Feature:
- Macro: LOOPBACK_CHECK_EN.
- Defined:
  - Adds output mismatch (1 bit, reset 0).
  - In WAIT_RDY on deser_ready_in=1, compare deser_data_in with the latched sent byte (a copy kept at grant).
  - On inequality, pulse mismatch for 1 cycle, coincident with rx_valid, and issue err[grant] instead of done[grant] at the end of ACK.
- Undefined: no mismatch port and no compare logic; completion always gives done.

Test Plan:
- Single transfer:
  - Stimulus: req=0001, req_data[7:0]=0xA5; model deserializer asserts ready 2 cycles after the last strobe and drops it 1 cycle after ack.
  - Required: ser_data_out shows 1,0,1,0,0,1,0,1 over 8 strobes; rx_byte=0xA5, rx_src=0, rx_valid pulses once; done[0] pulses; busy returns to 0.
- Round robin:
  - Stimulus: req=1111 held continuously with distinct bytes.
  - Required: grant order 0,1,2,3,0; each done appears once per transfer.
- Timeout:
  - Stimulus: req=0100; deser_ready_in held at 0.
  - Required: err[2] pulses exactly ACK_TIMEOUT cycles after entry to WAIT_RDY; done stays 0; return to IDLE.
- Stuck ready:
  - Stimulus: ready rises but never falls.
  - Required: deser_ack_out held for ACK_TIMEOUT cycles, then dropped; err pulses.
- Reset mid-shift:
  - Stimulus: assert reset after the 4th strobe.
  - Required: all outputs 0 immediately; after reset release with req=0010, requester 1 is granted with a fresh 8-bit shift.
- Loopback check (LOOPBACK_CHECK_EN defined):
  - Stimulus: sent byte 0x3C; model returns 0x3D.
  - Required: mismatch and rx_valid pulse together; err[grant] pulses and done does not.
